// File: rtl/pcm_conditioner.sv
// pcm_conditioner: decimates mapper PCM to a fixed sample rate, applies a
// one-pole low-pass, then a ramped volume/mute gain with saturation and a
// sticky clip flag. Output is a registered sample plus a one-cycle strobe.
//
// Build option: define PCM_CONDITIONER_DCBLOCK_EN to insert a DC-blocking
// stage (DCBLK) ahead of the low-pass. Latency then grows from 3 to 4 cycles.
//
// state  | meaning
// IDLE   | wait for the sample tick, capture pcm_in
// DCBLK  | DC tracker update and removal (optional build only)
// FILTER | low-pass update, gain ramp step
// SCALE  | apply gain, saturate, register output and strobe
// OUTPUT | strobe visible for this one cycle
module pcm_conditioner #(
    parameter int SAMPLE_DIV = 1000,
    parameter int SHIFT      = 4,
    parameter int RAMP_STEP  = 1
) (
    input  logic               clk,
    input  logic               async_nreset,
    input  logic signed [15:0] pcm_in,
    input  logic        [7:0]  volume,
    input  logic               mute,
    input  logic               clip_clear,
    output logic signed [15:0] pcm_out,
    output logic               out_valid,
    output logic               clip
);

    localparam int AW = 16 + SHIFT + 1;
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [8:0] RSTEP = 9'(RAMP_STEP);
    localparam logic signed [24:0] S_MAX = 25'sd32767;
    localparam logic signed [24:0] S_MIN = -25'sd32768;

    typedef enum logic [2:0] {
        IDLE,
`ifdef PCM_CONDITIONER_DCBLOCK_EN
        DCBLK,
`endif
        FILTER,
        SCALE,
        OUTPUT
    } state_t;

    state_t state;

    logic [DW-1:0]        divider;
    logic                 tick;
    logic signed [15:0]   x;
    logic signed [15:0]   y;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] x_ext;
    logic [7:0]           vol_cur;
    logic [7:0]           vol_next;
    logic [7:0]           target;
    logic [7:0]           diff;
    logic [7:0]           step;
    logic signed [24:0]   y_ext;
    logic signed [24:0]   g_ext;
    logic signed [24:0]   s_full;
    logic signed [15:0]   sat_val;
    logic                 sat_hit;

    assign tick = (divider == DW'(SAMPLE_DIV - 1));

    // Free-running sample-rate divider; tick on its last count.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            divider <= '0;
        end else if (tick) begin
            divider <= '0;
        end else begin
            divider <= divider + DW'(1);
        end
    end

    // Low-pass update, gain ramp toward target without overshoot, and gain/saturation.
    always_comb begin
        x_ext    = {{(AW-16){x[15]}}, x};
        acc_next = acc + x_ext - (acc >>> SHIFT);

        target   = mute ? 8'd0 : volume;
        diff     = 8'd0;
        step     = 8'd0;
        vol_next = vol_cur;
        if (vol_cur < target) begin
            diff     = target - vol_cur;
            step     = ({1'b0, diff} > RSTEP) ? RSTEP[7:0] : diff;
            vol_next = vol_cur + step;
        end else if (vol_cur > target) begin
            diff     = vol_cur - target;
            step     = ({1'b0, diff} > RSTEP) ? RSTEP[7:0] : diff;
            vol_next = vol_cur - step;
        end

        y_ext  = {{9{y[15]}}, y};
        g_ext  = {17'd0, vol_cur};
        s_full = (y_ext * g_ext) >>> 7;
        if (s_full > S_MAX) begin
            sat_val = 16'sh7FFF;
            sat_hit = 1'b1;
        end else if (s_full < S_MIN) begin
            sat_val = 16'sh8000;
            sat_hit = 1'b1;
        end else begin
            sat_val = s_full[15:0];
            sat_hit = 1'b0;
        end
    end

`ifdef PCM_CONDITIONER_DCBLOCK_EN
    localparam logic signed [26:0] D_MAX = 27'sd32767;
    localparam logic signed [26:0] D_MIN = -27'sd32768;

    logic signed [26:0] dc_acc;
    logic signed [26:0] dc_next;
    logic signed [26:0] dc_diff;
    logic signed [26:0] x_ext27;
    logic signed [15:0] x_blk;

    // DC tracker with ~1024-sample time constant; its estimate is subtracted from x.
    always_comb begin
        x_ext27 = {{11{x[15]}}, x};
        dc_next = dc_acc + x_ext27 - (dc_acc >>> 10);
        dc_diff = x_ext27 - (dc_next >>> 10);
        if (dc_diff > D_MAX) begin
            x_blk = 16'sh7FFF;
        end else if (dc_diff < D_MIN) begin
            x_blk = 16'sh8000;
        end else begin
            x_blk = dc_diff[15:0];
        end
    end
`endif

    // Sample pipeline FSM with registered output, strobe and sticky clip.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            acc       <= '0;
            vol_cur   <= '0;
            pcm_out   <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
`ifdef PCM_CONDITIONER_DCBLOCK_EN
            dc_acc    <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            // a saturating sample wins over a simultaneous clear
            if (state == SCALE && sat_hit) begin
                clip <= 1'b1;
            end else if (clip_clear) begin
                clip <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        x <= pcm_in;
`ifdef PCM_CONDITIONER_DCBLOCK_EN
                        state <= DCBLK;
`else
                        state <= FILTER;
`endif
                    end
                end
`ifdef PCM_CONDITIONER_DCBLOCK_EN
                DCBLK: begin
                    dc_acc <= dc_next;
                    x      <= x_blk;
                    state  <= FILTER;
                end
`endif
                FILTER: begin
                    acc     <= acc_next;
                    y       <= acc_next[SHIFT +: 16];
                    vol_cur <= vol_next;
                    state   <= SCALE;
                end
                SCALE: begin
                    pcm_out   <= sat_val;
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
